pw_lockout_ctrl: RTL

Downstream stage of the password-entry FSM. It consumes that FSM's 9-bit one-hot status bus and its divided state-update clock (`clk_div`).
- Counts consecutive wrong attempts.
- Grants a timed unlock on a correct entry.
- Enforces a timed lockout after MAX_FAILS consecutive failures.
- Exports `entry_inhibit` so top level can gate the upstream enable switch.

---
 rtl/pw_pkg.sv | 21 ++
 rtl/pw_edge_detect.sv | 34 +++
 rtl/pw_lockout_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// Purpose: shared types and defaults for the password lockout controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake in this block).
package pw_pkg;

    // Two-bit state code; 2'b11 is unused and recovers to ST_READY.
    typedef enum logic [1:0] {
        ST_READY    = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_LOCKOUT  = 2'b10
    } pw_state_t;

    // Bit positions inside the upstream password FSM one-hot status bus.
    localparam int STATUS_CORRECT_BIT   = 8;
    localparam int STATUS_INCORRECT_BIT = 7;

    localparam int DEF_MAX_FAILS    = 3;
    localparam int DEF_UNLOCK_TICKS = 5;
    localparam int DEF_LOCK_TICKS   = 30;

endpackage

// File: rtl/pw_edge_detect.sv
// Purpose: registered previous-value edge detector, per-bit rise and toggle.
// Latency: combinational from din against last cycle's value; history updates each clk.
// Backpressure: none; samples every clk.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   din       - vector to watch
//   rise      - din bit went 0->1 since last clk
//   toggle    - din bit changed since last clk
module pw_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise,
    output logic [W-1:0] toggle
);

    logic [W-1:0] din_q;

    // History loads the live value even in reset, so a level already present
    // when reset releases is never seen as an edge.
    always_ff @(posedge clk) begin
        din_q <= din;
    end

    // Events are masked while reset is asserted.
    always_comb begin
        rise   = din & ~din_q & {W{~rst}};
        toggle = (din ^ din_q) & {W{~rst}};
    end

endmodule

// File: rtl/pw_lockout_ctrl.sv
// Purpose: counts wrong password attempts, grants timed unlock, enforces timed lockout.
// Latency: an input change sampled at one clk edge is visible on outputs right after it.
// Backpressure: none; events arriving while UNLOCKED/LOCKOUT are dropped, never queued.
//
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   clk_div        - divided clock from password FSM; every toggle is one tick
//   status         - password FSM one-hot status (bit 8 correct, bit 7 incorrect)
//   unlocked       - high in UNLOCKED
//   locked_out     - high in LOCKOUT
//   entry_inhibit  - high whenever not READY
//   fail_count     - consecutive incorrect attempts
//   time_left      - ticks remaining in UNLOCKED/LOCKOUT, 0 in READY
module pw_lockout_ctrl
    import pw_pkg::*;
#(
    parameter int MAX_FAILS    = DEF_MAX_FAILS,
    parameter int UNLOCK_TICKS = DEF_UNLOCK_TICKS,
    parameter int LOCK_TICKS   = DEF_LOCK_TICKS,
    parameter int CNT_W        = 6,
    parameter int FAIL_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_div,
    input  logic [8:0]        status,
    output logic              unlocked,
    output logic              locked_out,
    output logic              entry_inhibit,
    output logic [FAIL_W-1:0] fail_count,
    output logic [CNT_W-1:0]  time_left
);

    localparam logic [FAIL_W-1:0] FAIL_LAST   = FAIL_W'(MAX_FAILS - 1);
    localparam logic [CNT_W-1:0]  UNLOCK_LOAD = CNT_W'(UNLOCK_TICKS);
    localparam logic [CNT_W-1:0]  LOCK_LOAD   = CNT_W'(LOCK_TICKS);

    pw_state_t         state_q, state_nx;
    logic [FAIL_W-1:0] fail_q, fail_nx;
    logic [CNT_W-1:0]  time_q, time_nx;

    logic       tick;
    logic       unused_clk_div_rise;
    logic [1:0] st_rise;
    logic [1:0] unused_st_toggle;
    logic       unused_status_bits;
    logic       ok_ev;
    logic       bad_ev;

    assign unused_status_bits = ^status[6:0];

    pw_edge_detect #(.W(1)) u_tick_det (
        .clk    (clk),
        .rst    (rst),
        .din    (clk_div),
        .rise   (unused_clk_div_rise),
        .toggle (tick)
    );

    // st_rise[1] = correct, st_rise[0] = incorrect.
    pw_edge_detect #(.W(2)) u_status_det (
        .clk    (clk),
        .rst    (rst),
        .din    ({status[STATUS_CORRECT_BIT], status[STATUS_INCORRECT_BIT]}),
        .rise   (st_rise),
        .toggle (unused_st_toggle)
    );

    // A simultaneous correct+incorrect rise is an illegal one-hot code and is
    // treated as a failure only.
    assign bad_ev = st_rise[0];
    assign ok_ev  = st_rise[1] & ~st_rise[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_READY;
            fail_q  <= '0;
            time_q  <= '0;
        end else begin
            state_q <= state_nx;
            fail_q  <= fail_nx;
            time_q  <= time_nx;
        end
    end

    // Next-state logic. In READY a coincident tick is ignored, so a freshly
    // loaded timer always gets its full count.
    always_comb begin
        state_nx = state_q;
        fail_nx  = fail_q;
        time_nx  = time_q;
        case (state_q)
            ST_READY: begin
                if (bad_ev) begin
                    if (fail_q == FAIL_LAST) begin
                        state_nx = ST_LOCKOUT;
                        fail_nx  = '0;
                        time_nx  = LOCK_LOAD;
                    end else begin
                        fail_nx = fail_q + FAIL_W'(1);
                    end
                end else if (ok_ev) begin
                    state_nx = ST_UNLOCKED;
                    fail_nx  = '0;
                    time_nx  = UNLOCK_LOAD;
                end
            end
            ST_UNLOCKED, ST_LOCKOUT: begin
                if (tick) begin
                    if (time_q <= CNT_W'(1)) begin
                        state_nx = ST_READY;
                        time_nx  = '0;
                    end else begin
                        time_nx = time_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_READY;
                fail_nx  = '0;
                time_nx  = '0;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        unlocked      = (state_q == ST_UNLOCKED);
        locked_out    = (state_q == ST_LOCKOUT);
        entry_inhibit = (state_q != ST_READY);
        fail_count    = fail_q;
        time_left     = time_q;
    end

endmodule
